// File: rtl/rr_encoder_arbiter.sv
// 8-requester round-robin arbiter with registered one-hot grant and binary owner index.
// Optional hold-limit revocation is enabled by defining ARB_TIMEOUT_EN.
module rr_encoder_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_cfg_check
        $error("rr_encoder_arbiter: MAX_HOLD must be 2..255 and fit in CNT_W bits");
    end

    // Rotate so bit 0 is the search start, take the lowest set bit, rotate the index back.
    // Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [3:0]  res;
        dbl = {vec, vec} >> start;
        rot = dbl[7:0];
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) res = {1'b1, 3'(i) + start};
        end
        return res;
    endfunction

    logic [0:0] r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_idx;
    logic [7:0] r_gnt;
    logic       r_timeout;

    logic [0:0] w_nxt_state;
    logic [2:0] w_nxt_ptr;
    logic [2:0] w_nxt_idx;
    logic       w_load;
    logic       w_revoke;
    logic       w_hold_expired;
    logic [7:0] w_others;
    logic [3:0] w_pick_ptr;
    logic [3:0] w_pick_next;

    assign w_others    = req & ~r_gnt;
    assign w_pick_ptr  = rr_pick(req, r_ptr);
    assign w_pick_next = rr_pick(w_others, r_idx + 3'd1);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_idx   = r_idx;
        w_load      = 1'b0;
        w_revoke    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (en && w_pick_ptr[3]) begin
                w_nxt_state = ST_BUSY;
                w_nxt_idx   = w_pick_ptr[2:0];
                w_load      = 1'b1;
            end
        end else if (!req[r_idx]) begin
            // Owner released: hand over on the same edge so gnt_vld never drops.
            w_nxt_ptr = r_idx + 3'd1;
            if (en && w_pick_next[3]) begin
                w_nxt_idx = w_pick_next[2:0];
                w_load    = 1'b1;
            end else begin
                w_nxt_state = ST_IDLE;
                w_nxt_idx   = 3'd0;
            end
        end else if (w_hold_expired && en && w_pick_next[3]) begin
            w_nxt_ptr = r_idx + 3'd1;
            w_nxt_idx = w_pick_next[2:0];
            w_load    = 1'b1;
            w_revoke  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_idx   <= 3'd0;
            r_gnt   <= 8'd0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_idx   <= w_nxt_idx;
            r_gnt   <= (w_nxt_state == ST_BUSY) ? (8'd1 << w_nxt_idx) : 8'd0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;

    assign w_hold_expired = (r_cnt == HOLD_LAST);

    // Counter saturates at the limit when nobody else is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_revoke;
            if (w_load) begin
                r_cnt <= '0;
            end else if (r_state == ST_BUSY && !w_hold_expired) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    assign w_hold_expired = 1'b0;
    assign r_timeout      = 1'b0;
`endif

    assign gnt     = r_gnt;
    assign gnt_idx = r_idx;
    assign gnt_vld = (r_state == ST_BUSY);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_rr_encoder_arbiter;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    exp_t exp_q[$];
    logic done;
    int   n_checks;
    int   n_fails;
    int   n_cycles;

    rr_encoder_arbiter #(
        .MAX_HOLD(4),
        .CNT_W   (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .req    (req),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then queue what the outputs must show for the new cycle.
    task automatic cyc(input logic vld, input logic [2:0] idx, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        e.vld = vld;
        e.idx = idx;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act != req_v) begin
            n_fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, n_cycles, act, req_v);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] eg;
        n_cycles++;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            eg = e.vld ? (8'd1 << e.idx) : 8'd0;
            chk("gnt", int'(gnt), int'(eg));
            chk("gnt_idx", int'(gnt_idx), int'(e.vld ? e.idx : 3'd0));
            chk("gnt_vld", int'(gnt_vld), int'(e.vld));
            chk("timeout", int'(timeout), int'(e.to));
        end
        if (done) begin
            chk("queue_drained", exp_q.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end else if (n_cycles > 3000) begin
            chk("watchdog", n_cycles, 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
            $finish;
        end
    end

    initial begin
        done     = 1'b0;
        n_checks = 0;
        n_fails  = 0;
        n_cycles = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        req      = 8'h00;

        // Reset state
        repeat (3) cyc(1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (10) cyc(1'b0, 3'd0, 1'b0);

        // 0x90 from ptr=0 grants 4, then hand-over to 7 without a gap
        req = 8'h90;
        cyc(1'b1, 3'd4, 1'b0);
        cyc(1'b1, 3'd4, 1'b0);
        req = 8'h80;
        cyc(1'b1, 3'd7, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);

        // All requesting: strict rotation 0..7,0 (ptr=0 here)
        req = 8'hFF;
        cyc(1'b1, 3'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b1, 3'(k % 8), 1'b0);
            cyc(1'b1, 3'(k % 8), 1'b0);
            if (k < 8) begin
                req = 8'hFF & ~(8'd1 << (k % 8));
                cyc(1'b1, 3'((k + 1) % 8), 1'b0);
                req = 8'hFF;
            end else begin
                req = 8'h00;
                cyc(1'b0, 3'd0, 1'b0);
            end
        end

        // en=0 while busy: owner 3 keeps grant, release goes idle, en=1 grants 5 (ptr=1)
        req = 8'h08;
        cyc(1'b1, 3'd3, 1'b0);
        en  = 1'b0;
        req = 8'h28;
        cyc(1'b1, 3'd3, 1'b0);
        req = 8'h20;
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        en = 1'b1;
        cyc(1'b1, 3'd5, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);

        // en=0 blocks grants from idle; lone re-requester waits one idle cycle (ptr=6)
        en  = 1'b0;
        req = 8'h04;
        cyc(1'b0, 3'd0, 1'b0);
        cyc(1'b0, 3'd0, 1'b0);
        en = 1'b1;
        cyc(1'b1, 3'd2, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);
        req = 8'h04;
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd2, 1'b0);

        // Asynchronous reset mid-cycle while gnt=0x04: outputs clear before the next edge
        @(posedge clk);
        #1;
        exp_q.push_back(exp_t'{vld: 1'b0, idx: 3'd0, to: 1'b0});
        #2 rst_n = 1'b0;
        cyc(1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        req   = 8'h06;
        cyc(1'b1, 3'd1, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);

        // Search wraps 7 -> 0 (ptr=2)
        req = 8'h80;
        cyc(1'b1, 3'd7, 1'b0);
        req = 8'h03;
        cyc(1'b1, 3'd0, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);

        // Hold limit (ptr=1, so 0x03 starts with owner 1)
        req = 8'h03;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(1'b1, (k == 1) ? 3'd0 : 3'd1, (k > 0 && c == 0));
            end
        end
        req = 8'h02;
        repeat (20) cyc(1'b1, 3'd1, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);
`else
        repeat (20) cyc(1'b1, 3'd1, 1'b0);
        req = 8'h01;
        cyc(1'b1, 3'd0, 1'b0);
        req = 8'h00;
        cyc(1'b0, 3'd0, 1'b0);
`endif

        done = 1'b1;
    end

endmodule

// File: doc/rr_encoder_arbiter.md
Name: rr_encoder_arbiter

Overview:
- 8-requester round-robin arbiter that shares one downstream resource between channels 0-7.
- Issues a registered one-hot grant and the 3-bit binary index of the winner, in the same encoding as the team's 8-to-3 encoder.
- A grant is held for as long as its owner keeps its request asserted.
- Sits between request sources and the shared resource; gnt_idx drives the resource's channel select directly.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant. Used only with ARB_TIMEOUT_EN. Legal range 2..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- en  input  1  arbitration enable. Low blocks new grants; the current owner keeps its grant.
- req  input  8  request lines; bit k = requester k.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the owner, registered; 0 when gnt_vld=0.
- gnt_vld  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, state=IDLE, rr pointer ptr=0, hold counter=0.
- FSM has two states:
  - IDLE: no owner.
  - BUSY: one owner, index held in a register.
- IDLE -> BUSY:
  - Condition: en=1 and req!=0.
  - Winner = first set bit of req, searching upward from ptr with wrap 7->0.
  - Latency: a request sampled at edge N gives gnt/gnt_idx/gnt_vld valid after edge N (visible in cycle N+1).
- BUSY, owner's req still 1: hold the grant; outputs stable.
- BUSY, owner's req sampled 0:
  - ptr <= owner+1 (mod 8).
  - If en=1 and another req bit is set, grant the next winner on the same edge, searching from owner+1. No idle cycle; gnt_vld stays 1.
  - Otherwise go to IDLE and clear gnt, gnt_idx and gnt_vld.
- Fairness: an owner that releases cannot win again until every other active requester has been served once, unless none are requesting.
- Boundary cases:
  - req=8'hFF with ptr=0: order of grants is 0,1,...,7,0 as each owner releases.
  - Only the released owner re-requests on the next cycle: it is granted again, but only after one IDLE cycle, because its req was 0 at the release edge.
  - ptr=7 wraps to 0. The search is a priority encode over the request vector rotated by ptr; result is (rotated_index+ptr) mod 8.
  - en=0 while BUSY: the owner keeps its grant. If the owner releases while en=0, go to IDLE and stay there until en=1.
  - Reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld equals |gnt.
  - gnt_idx equals the binary encoding of gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter resets to 0 on every new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 while any other req bit is set and en=1: revoke the owner and grant the next winner (search from owner+1). ptr <= owner+1. timeout pulses 1 for that cycle.
  - With no other requester, the owner keeps the grant and the counter saturates.
- Not defined: no counter logic; grants are held indefinitely; timeout is tied 0.

Test Plan:
- Reset, then req=8'h00, en=1 -> gnt=0, gnt_vld=0, gnt_idx=0 for 10 cycles.
- req=8'h90 from reset (ptr=0) -> gnt=8'h10, gnt_idx=4 one cycle later. Drop req[4] -> next edge gnt=8'h80, gnt_idx=7, gnt_vld stays 1.
- req=8'hFF held, each owner drops its bit for exactly 1 cycle after 3 cycles of ownership -> grant order 0,1,2,3,4,5,6,7,0; never two bits set in gnt.
- Owner 3 granted, set en=0, raise req[5], drop req[3] -> IDLE, gnt=0. Set en=1 -> gnt=8'h20, idx=5 one cycle later.
- Assert rst_n=0 mid-cycle while gnt=8'h04 -> gnt/gnt_vld/gnt_idx go to 0 before the next edge. After release, ptr=0, so req=8'h06 grants idx=1.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held -> idx 0 for 4 cycles, timeout pulse, idx 1 for 4 cycles, timeout pulse, idx 0 again. With req=8'h01 only -> idx 0 held indefinitely, no timeout.
